serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - borrowin using one full-adder cell
// Computes A + ~B + ~borrowin LSB-first; busy/done/result/flags are all registered.
module serial_subtractor #(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               borrowin,
    output logic [NUMBITS-1:0] result,
    output logic               borrowout,
    output logic               overflow,
    output logic               busy,
    output logic               done
);
    localparam int CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               c_q, c_d;
    logic [NUMBITS-1:0] sa_q, sa_d;
    logic [NUMBITS-1:0] sb_q, sb_d;
    logic [NUMBITS-1:0] diff_q, diff_d;
    logic               ovf_q, ovf_d;
    logic [NUMBITS-1:0] result_q, result_d;
    logic               borrowout_q, borrowout_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic a_bit, nb_bit, sum_bit, carry_next;

    // The single full-adder cell, fed with the inverted subtrahend bit.
    always_comb begin
        a_bit      = sa_q[0];
        nb_bit     = ~sb_q[0];
        sum_bit    = a_bit ^ nb_bit ^ c_q;
        carry_next = (a_bit & nb_bit) | (a_bit & c_q) | (nb_bit & c_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        diff_d      = diff_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        borrowout_d = borrowout_q;
        overflow_d  = overflow_q;
        busy_d      = (state_q == RUN);
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    c_d     = ~borrowin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = {sum_bit, diff_q[NUMBITS-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                c_d    = carry_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Carry into the MSB vs carry out of it.
                    ovf_d   = c_q ^ carry_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d    = diff_q;
                borrowout_d = ~c_q;
                overflow_d  = ovf_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            sa_q        <= '0;
            sb_q        <= '0;
            diff_q      <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            borrowout_q <= borrowout_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign borrowout = borrowout_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
// Directed table, handshake/reset sequences and random ops against an arithmetic model.
module tb_serial_subtractor;
    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst16, start16, bin16;
    logic [N-1:0]  a16, b16, res16;
    logic          bo16, ov16, busy16, done16;

    logic          rst4, start4, bin4;
    logic [3:0]    a4, b4, res4;
    logic          bo4, ov4, busy4, done4;

    serial_subtractor #(.NUMBITS(N)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .A(a16), .B(b16), .borrowin(bin16),
        .result(res16), .borrowout(bo16), .overflow(ov16), .busy(busy16), .done(done16)
    );

    serial_subtractor #(.NUMBITS(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .borrowin(bin4),
        .result(res4), .borrowout(bo4), .overflow(ov4), .busy(busy4), .done(done4)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                  output logic [15:0] r, output logic bo, output logic ov);
        int sd;
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r  = 16'(int'(a) - int'(b) - int'(bin));
        bo = (int'(a) < int'(b) + int'(bin));
        ov = (sd > 32767) || (sd < -32768);
    endfunction

    // One operation on dut16 with a cycle-exact check of the busy/done pattern.
    task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] er, input logic ebo, input logic eov);
        logic timing_ok;
        @(negedge clk);
        a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
        timing_ok = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            if (k <= N) timing_ok &= (busy16 === 1'b1) && (done16 === 1'b0);
            else        timing_ok &= (busy16 === 1'b0) && (done16 === 1'b1);
        end
        check({name, " value"}, {14'd0, res16, bo16, ov16}, {14'd0, er, ebo, eov});
        @(posedge clk); #1;
        timing_ok &= (done16 === 1'b0) && (busy16 === 1'b0);
        check({name, " timing"}, {31'd0, timing_ok}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [15:0] a, b;
        logic        bin;
        logic [15:0] r;
        logic        bo, ov;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb, er;
        logic        rbin, ebo, eov;
        int          cyc, t_first, t_second, ndone, waited;
        logic        seen;

        vecs[0] = '{"basic",        16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{"borrowin",     16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        vecs[2] = '{"ovf_neg",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{"ovf_pos",      16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[4] = '{"max_minus_1",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{"equal",        16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{"zero_bin",     16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst16 = 1'b1; start16 = 1'b1; a16 = 16'h0005; b16 = 16'h0003; bin16 = 1'b0;
        rst4 = 1'b1;  start4 = 1'b0;  a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;

        // Reset held with start asserted: everything stays cleared.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset outputs", {13'd0, res16, bo16, ov16, busy16, done16}, 32'd0);
        end
        @(negedge clk);
        rst16 = 1'b0; rst4 = 1'b0; start16 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy16 !== 1'b0 || done16 !== 1'b0) seen = 1'b1;
        end
        check("idle after reset", {31'd0, seen}, 32'd0);

        foreach (vecs[i])
            run16(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].r, vecs[i].bo, vecs[i].ov);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h7FFF; end
            model(ra, rb, rbin, er, ebo, eov);
            run16($sformatf("rand%0d", i), ra, rb, rbin, er, ebo, eov);
        end

        // start pulsed while busy must be ignored.
        @(negedge clk);
        a16 = 16'h0005; b16 = 16'h0003; bin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start16 = 1'b0;
        cyc = 0; waited = 0;
        while (done16 !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            cyc++; waited++;
            if (cyc == 3) begin
                @(negedge clk);
                a16 = 16'hFFFF; b16 = 16'h1234; bin16 = 1'b1; start16 = 1'b1;
                @(posedge clk); #1;
                cyc++; waited++;
                @(negedge clk); start16 = 1'b0;
            end
        end
        check("busy start latency", cyc, N + 1);
        check("busy start ignored", {15'd0, res16, bo16, ov16}, {15'd0, 16'h0002, 1'b0, 1'b0});
        seen = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (busy16 === 1'b1 || done16 === 1'b1) seen = 1'b1;
        end
        check("no queued launch", {31'd0, seen}, 32'd0);

        // start held high: back-to-back launches, done spaced NUMBITS+2.
        @(negedge clk);
        a16 = 16'h0100; b16 = 16'h0001; bin16 = 1'b0; start16 = 1'b1;
        cyc = 0; ndone = 0; t_first = 0; t_second = 0;
        while (ndone < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done16 === 1'b1) begin
                ndone++;
                if (ndone == 1) t_first = cyc; else t_second = cyc;
                check("held start value", {15'd0, res16, bo16, ov16}, {15'd0, 16'h00FF, 1'b0, 1'b0});
            end
            if (busy16 === 1'b1 && done16 === 1'b1) check("busy and done together", 32'd1, 32'd0);
        end
        check("held start done count", ndone, 2);
        check("held start spacing", t_second - t_first, N + 2);
        @(negedge clk);
        rst16 = 1'b1; start16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset after relaunch", {13'd0, res16, bo16, ov16, busy16, done16}, 32'd0);
        @(negedge clk); rst16 = 1'b0;

        // 4-bit instance: reset during the second RUN cycle abandons the op.
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst4 = 1'b1;
        @(posedge clk); #1;
        check("n4 mid reset outputs", {25'd0, res4, bo4, ov4, busy4}, 32'd0);
        @(negedge clk); rst4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
        end
        check("n4 no done after reset", {31'd0, seen}, 32'd0);
        check("n4 outputs still clear", {26'd0, res4, bo4, ov4}, 32'd0);

        @(negedge clk);
        a4 = 4'h9; b4 = 4'h2; start4 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start4 = 1'b0; a4 = 4'h0; b4 = 4'hF;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("n4 latency", cyc, 5);
        // 9 - 2 = 7; as signed 4-bit, -7 - 2 = -9 overflows.
        check("n4 fresh result", {26'd0, res4, bo4, ov4}, {26'd0, 4'h7, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
